// File: rtl/viterbi_burst_channel.sv
`timescale 1ns/1ps
// Channel model between convolutional encoder and Viterbi decoder: injects
// periodic or LFSR-driven bit-error bursts into W-bit coded symbols.
module viterbi_burst_channel #(
  parameter int unsigned W        = 2,
  parameter int unsigned PERIOD_W = 8,
  parameter int unsigned BURST_W  = 4,
  parameter int unsigned CNT_W    = 16,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          mode_i,
  input  logic [PERIOD_W-1:0] period_i,
  input  logic [BURST_W-1:0]  burst_len_i,
  input  logic [7:0]          thresh_i,
  input  logic                valid_i,
  input  logic [W-1:0]        sym_i,
  output logic                valid_o,
  output logic [W-1:0]        sym_o,
  output logic                err_o,
  output logic [CNT_W-1:0]    burst_ct_o,
  output logic [CNT_W-1:0]    bit_err_ct_o
);

  localparam int unsigned POP_W = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;

  state_t              state;
  logic [15:0]         lfsr;
  logic [PERIOD_W-1:0] win_ct;
  logic [PERIOD_W-1:0] offset;
  logic [BURST_W-1:0]  remaining;
  logic [1:0]          mode_q;
  logic [PERIOD_W-1:0] period_q;
  logic [BURST_W-1:0]  burst_len_q;
  logic [7:0]          thresh_q;

  logic                win_start, enabled, start, go_wait, corrupt;
  logic [1:0]          cur_mode;
  logic [PERIOD_W-1:0] cur_period, rand_off, win_next;
  logic [PERIOD_W:0]   wc_inc;
  logic [BURST_W-1:0]  cur_burst_len, rem_eff, rem_next;
  logic [7:0]          cur_thresh;
  logic [W-1:0]        mask, mask_eff;
  logic [POP_W-1:0]    pop;
  logic [CNT_W:0]      burst_sum, bit_sum;
  logic [15:0]         lfsr_next;

  // Window start uses the live config inputs, which are latched for the rest of the window.
  assign win_start     = (win_ct == '0);
  assign cur_mode      = win_start ? mode_i      : mode_q;
  assign cur_period    = win_start ? period_i    : period_q;
  assign cur_burst_len = win_start ? burst_len_i : burst_len_q;
  assign cur_thresh    = win_start ? thresh_i    : thresh_q;
  assign enabled       = (cur_mode != 2'd0) && (cur_period >= PERIOD_W'(2)) && (cur_burst_len != '0);

  assign rand_off  = lfsr[PERIOD_W-1:0];
  assign lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign wc_inc    = {1'b0, win_ct} + (PERIOD_W+1)'(1);
  assign win_next  = (wc_inc >= {1'b0, cur_period}) ? '0 : wc_inc[PERIOD_W-1:0];

  always_comb begin
    start   = 1'b0;
    go_wait = 1'b0;
    case (state)
      IDLE: begin
        if (win_start && enabled) begin
          if (cur_mode == 2'd1) begin
            start = 1'b1;
          end else if ((lfsr[15:8] < cur_thresh) && (rand_off < cur_period)) begin
            if (rand_off == '0) start = 1'b1;
            else                go_wait = 1'b1;
          end
        end
      end
      WAIT:    start = (win_ct == offset);
      default: ;
    endcase
  end

  assign corrupt  = start || (state == BURST);
  assign rem_eff  = (state == BURST) ? remaining : cur_burst_len;
  assign rem_next = rem_eff - BURST_W'(1);

  always_comb begin
    if (cur_mode == 2'd3) mask = W'(1) << (32'(lfsr[3:0]) % W);
    else                  mask = '1;
    mask_eff = corrupt ? mask : '0;
    pop = '0;
    for (int unsigned i = 0; i < W; i++) pop = pop + POP_W'(mask_eff[i]);
  end

  assign burst_sum = {1'b0, burst_ct_o}   + (CNT_W+1)'(start);
  assign bit_sum   = {1'b0, bit_err_ct_o} + (CNT_W+1)'(pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      lfsr         <= SEED;
      win_ct       <= '0;
      offset       <= '0;
      remaining    <= '0;
      mode_q       <= '0;
      period_q     <= '0;
      burst_len_q  <= '0;
      thresh_q     <= '0;
      valid_o      <= 1'b0;
      sym_o        <= '0;
      err_o        <= 1'b0;
      burst_ct_o   <= '0;
      bit_err_ct_o <= '0;
    end else if (valid_i) begin
      if (win_start) begin
        mode_q      <= mode_i;
        period_q    <= period_i;
        burst_len_q <= burst_len_i;
        thresh_q    <= thresh_i;
      end
      lfsr    <= lfsr_next;
      win_ct  <= win_next;
      valid_o <= 1'b1;
      sym_o   <= sym_i ^ mask_eff;
      err_o   <= corrupt;
      if (corrupt) begin
        remaining <= rem_next;
        state     <= (rem_next == '0) ? IDLE : BURST;
      end else if (go_wait) begin
        offset <= rand_off;
        state  <= WAIT;
      end
      burst_ct_o   <= burst_sum[CNT_W] ? '1 : burst_sum[CNT_W-1:0];
      bit_err_ct_o <= bit_sum[CNT_W]   ? '1 : bit_sum[CNT_W-1:0];
    end else begin
      valid_o <= 1'b0;
      err_o   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_viterbi_burst_channel.sv
`timescale 1ns/1ps
// Scoreboard bench for viterbi_burst_channel: a window/burst reference model
// predicts each output symbol; a separate monitor pops and compares.
module tb_viterbi_burst_channel;
  localparam int W = 2, PW = 8, BW = 4, CW = 16;

  logic          clk = 1'b0, rst = 1'b1;
  logic [1:0]    mode_i = '0;
  logic [PW-1:0] period_i = '0;
  logic [BW-1:0] burst_len_i = '0;
  logic [7:0]    thresh_i = '0;
  logic          valid_i = 1'b0;
  logic [W-1:0]  sym_i = '0;
  logic          valid_o, err_o;
  logic [W-1:0]  sym_o;
  logic [CW-1:0] burst_ct_o, bit_err_ct_o;
  logic          s_valid, s_err;
  logic [W-1:0]  s_sym;
  logic [3:0]    s_burst, s_bits;

  viterbi_burst_channel #(.W(W), .PERIOD_W(PW), .BURST_W(BW), .CNT_W(CW), .SEED(16'hACE1)) dut (
    .clk(clk), .rst(rst), .mode_i(mode_i), .period_i(period_i), .burst_len_i(burst_len_i),
    .thresh_i(thresh_i), .valid_i(valid_i), .sym_i(sym_i), .valid_o(valid_o), .sym_o(sym_o),
    .err_o(err_o), .burst_ct_o(burst_ct_o), .bit_err_ct_o(bit_err_ct_o));

  // Narrow-counter instance used to reach saturation quickly.
  viterbi_burst_channel #(.W(W), .PERIOD_W(PW), .BURST_W(BW), .CNT_W(4), .SEED(16'hACE1)) sat_dut (
    .clk(clk), .rst(rst), .mode_i(mode_i), .period_i(period_i), .burst_len_i(burst_len_i),
    .thresh_i(thresh_i), .valid_i(valid_i), .sym_i(sym_i), .valid_o(s_valid), .sym_o(s_sym),
    .err_o(s_err), .burst_ct_o(s_burst), .bit_err_ct_o(s_bits));

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] orig;
    logic [W-1:0] exp;
    logic         err;
    logic         single;
  } exp_t;

  exp_t q[$];
  int errors = 0, checks = 0;

  int unsigned m_lfsr;
  int m_pos, m_mode, m_period, m_blen, m_thresh, m_left, m_target;
  longint m_bursts, m_bits;

  function automatic int ones(longint unsigned v);
    int n = 0;
    for (int i = 0; i < 64; i++) n += int'(v[i]);
    return n;
  endfunction

  function automatic longint sat16(longint v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_lfsr = 32'hACE1; m_pos = 0; m_left = 0; m_target = -1;
    m_mode = 0; m_period = 0; m_blen = 0; m_thresh = 0;
    m_bursts = 0; m_bits = 0;
  endtask

  // One valid symbol through the channel: window bookkeeping, burst scheduling, corruption.
  task automatic model_step(input logic [W-1:0] s, output exp_t e);
    int unsigned mask = 0;
    if (m_pos == 0) begin
      m_mode = int'(mode_i); m_period = int'(period_i);
      m_blen = int'(burst_len_i); m_thresh = int'(thresh_i);
    end
    if (m_pos == 0 && m_left == 0 && m_target < 0 && m_mode != 0 && m_period >= 2 && m_blen != 0) begin
      if (m_mode == 1) m_target = 0;
      else if (int'(m_lfsr >> 8) < m_thresh && int'(m_lfsr & ((1 << PW) - 1)) < m_period)
        m_target = int'(m_lfsr & ((1 << PW) - 1));
    end
    if (m_target >= 0 && m_pos == m_target) begin
      m_left = m_blen; m_target = -1; m_bursts++;
    end
    if (m_left > 0) begin
      mask = (m_mode == 3) ? (1 << ((m_lfsr & 15) % W)) : ((1 << W) - 1);
      m_left--;
      m_bits += ones(mask);
    end
    e.orig = s;
    e.exp = s ^ mask[W-1:0];
    e.err = (mask != 0);
    e.single = (m_mode == 3);
    m_lfsr = ((m_lfsr << 1) | (ones(m_lfsr & 32'hB400) & 1)) & 32'hFFFF;
    m_pos = (m_pos + 1 >= m_period) ? 0 : m_pos + 1;
  endtask

  task automatic send(input logic v, input logic [W-1:0] s);
    exp_t e;
    @(negedge clk);
    valid_i = v;
    sym_i = s;
    if (v) begin
      model_step(s, e);
      q.push_back(e);
    end
  endtask

  task automatic drain();
    repeat (3) send(1'b0, '0);
    chk("drain", q.size(), 0);
  endtask

  task automatic do_reset(input bit expect_burst);
    @(negedge clk);
    valid_i = 1'b0;
    if (expect_burst) chk("in_burst_before_rst", err_o, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_valid_o", valid_o, 0);
    chk("rst_sym_o", sym_o, 0);
    chk("rst_err_o", err_o, 0);
    chk("rst_burst_ct", burst_ct_o, 0);
    chk("rst_bit_err_ct", bit_err_ct_o, 0);
    model_reset();
    q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_counts(input string name);
    chk({name, "_burst_ct"}, burst_ct_o, sat16(m_bursts));
    chk({name, "_bit_err_ct"}, bit_err_ct_o, sat16(m_bits));
  endtask

  // Monitor: every presented symbol is compared against the oldest prediction.
  initial begin
    exp_t e;
    logic [W-1:0] last = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        last = sym_o;
      end else if (valid_o) begin
        if (q.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          e = q.pop_front();
          chk("sym_o", sym_o, e.exp);
          chk("err_o", err_o, e.err);
          if (e.err && e.single) chk("single_bit_flip", ones(sym_o ^ e.orig), 1);
        end
        last = sym_o;
      end else begin
        chk("idle_err_o", err_o, 0);
        chk("idle_sym_hold", sym_o, last);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();

    // Pass-through
    mode_i = 2'd0; period_i = 8'd10; burst_len_i = 4'd3; thresh_i = 8'd255;
    do_reset(0);
    for (int i = 0; i < 100; i++) send(1'b1, W'($urandom));
    drain();
    chk("pass_burst_ct", burst_ct_o, 0);
    chk("pass_bit_err_ct", bit_err_ct_o, 0);

    // Periodic bursts
    mode_i = 2'd1; period_i = 8'd32; burst_len_i = 4'd2;
    do_reset(0);
    for (int i = 0; i < 128; i++) send(1'b1, W'($urandom));
    drain();
    chk("periodic_burst_ct", burst_ct_o, 4);
    chk("periodic_bit_err_ct", bit_err_ct_o, 16);

    // Random, never triggers
    mode_i = 2'd2; period_i = 8'd20; burst_len_i = 4'd3; thresh_i = 8'd0;
    do_reset(0);
    for (int i = 0; i < 1000; i++) send(1'b1, W'($urandom));
    drain();
    chk("rand_thresh0_burst_ct", burst_ct_o, 0);

    // Random, almost always triggers
    period_i = 8'd255; thresh_i = 8'd255;
    do_reset(0);
    for (int i = 0; i < 600; i++) send(1'b1, W'($urandom));
    drain();
    check_counts("rand_full");

    // Single-bit random errors
    mode_i = 2'd3; period_i = 8'd16; burst_len_i = 4'd4; thresh_i = 8'd255;
    do_reset(0);
    for (int i = 0; i < 300; i++) send(1'b1, W'($urandom));
    for (int k = 0; k < 64 && (m_left > 0 || m_target >= 0); k++) send(1'b1, W'($urandom));
    drain();
    check_counts("single");
    chk("single_bits_eq_4x_bursts", bit_err_ct_o, 4 * longint'(burst_ct_o));

    // Mid-window burst_len change takes effect next window
    mode_i = 2'd1; period_i = 8'd8; burst_len_i = 4'd2;
    do_reset(0);
    for (int i = 0; i < 3; i++) send(1'b1, W'($urandom));
    burst_len_i = 4'd4;
    for (int i = 0; i < 13; i++) send(1'b1, W'($urandom));
    drain();
    chk("cfg_change_burst_ct", burst_ct_o, 2);
    chk("cfg_change_bit_err_ct", bit_err_ct_o, 12);

    // Stalls during bursts
    burst_len_i = 4'd5;
    for (int i = 0; i < 80; i++) send(1'($urandom_range(0, 1)), W'($urandom));
    drain();
    check_counts("stall");

    // Burst longer than the window
    period_i = 8'd8; burst_len_i = 4'd15;
    do_reset(0);
    for (int i = 0; i < 16; i++) send(1'b1, W'($urandom));
    drain();
    chk("long_burst_ct", burst_ct_o, 1);
    chk("long_bit_err_ct", bit_err_ct_o, 30);
    send(1'b1, W'($urandom));
    drain();
    chk("long_next_burst_ct", burst_ct_o, 2);

    // Reset in the middle of a burst
    period_i = 8'd32; burst_len_i = 4'd10;
    do_reset(0);
    for (int i = 0; i < 4; i++) send(1'b1, W'($urandom));
    do_reset(1);
    for (int i = 0; i < 4; i++) send(1'b1, W'($urandom));
    drain();
    chk("post_rst_burst_ct", burst_ct_o, 1);
    chk("post_rst_bit_err_ct", bit_err_ct_o, 8);

    // Counter saturation on the narrow instance
    period_i = 8'd2; burst_len_i = 4'd1;
    do_reset(0);
    for (int i = 0; i < 10; i++) send(1'b1, W'($urandom));
    drain();
    chk("sat_burst_mid", s_burst, 5);
    chk("sat_bits_mid", s_bits, 10);
    for (int i = 0; i < 30; i++) send(1'b1, W'($urandom));
    drain();
    chk("sat_burst_hold", s_burst, 15);
    chk("sat_bits_hold", s_bits, 15);
    check_counts("sat_wide");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
